// File: rtl/key_scan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner (key_scan, key_matrix_sampler).
package key_scan_pkg;
   localparam int KS_NUM_COLS = 4;
   localparam int KS_NUM_ROWS = 4;
   localparam int KS_CODE_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEBOUNCE,
      ST_PRESSED,
      ST_RELEASE
   } ks_state_t;

   typedef enum logic [1:0] {
      FC_NONE,
      FC_SINGLE,
      FC_MULTI
   } ks_class_t;
endpackage

// File: rtl/key_matrix_sampler.sv
// Column drive, end-of-column row sampling and whole-frame closure classification.
// frame_done is a combinational strobe on the last cycle of column 3, qualifying class/code.
module key_matrix_sampler
   import key_scan_pkg::*;
#(
   parameter int SCAN_DIV = 4096
) (
   input  logic                   scanclk,
   input  logic                   reset,
   input  logic [KS_NUM_ROWS-1:0] row_in,
   output logic [KS_NUM_COLS-1:0] col_out,
   output logic                   frame_done,
   output logic [1:0]             frame_class,
   output logic [KS_CODE_W-1:0]   frame_code
);
   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam int NUM_KEYS = KS_NUM_COLS * KS_NUM_ROWS;

   logic [DIV_W-1:0]               div;
   logic [1:0]                     col_idx;
   logic [NUM_KEYS-KS_NUM_ROWS-1:0] closed;
   logic                           div_last;
   logic [NUM_KEYS-1:0]            hits;
   logic [1:0]                     n_hit;

   assign div_last   = (div == DIV_LAST);
   assign frame_done = div_last && (col_idx == 2'(KS_NUM_COLS - 1));

   always_ff @(posedge scanclk or posedge reset) begin
      if (reset) begin
         div     <= '0;
         col_idx <= '0;
         col_out <= 4'b1110;
         closed  <= '0;
      end else if (div_last) begin
         div     <= '0;
         col_idx <= col_idx + 2'd1;
         col_out <= {col_out[KS_NUM_COLS-2:0], col_out[KS_NUM_COLS-1]};
         // Column 3 is never stored: its rows are classified live at frame end.
         if (col_idx != 2'(KS_NUM_COLS - 1))
            closed[{col_idx, 2'b00} +: KS_NUM_ROWS] <= ~row_in;
      end else begin
         div <= div + 1'b1;
      end
   end

   // Bit index col*4+row equals the key code, so the last hit found is the single key.
   always_comb begin
      hits        = {~row_in, closed};
      n_hit       = 2'd0;
      frame_code  = '0;
      frame_class = FC_NONE;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (hits[i]) begin
            frame_code = KS_CODE_W'(i);
            if (n_hit != 2'd2)
               n_hit = n_hit + 2'd1;
         end
      end
      case (n_hit)
         2'd0:    frame_class = FC_NONE;
         2'd1:    frame_class = FC_SINGLE;
         default: frame_class = FC_MULTI;
      endcase
   end
endmodule

// File: rtl/key_scan.sv
// 4x4 keypad scanner: frame-level debounce FSM and sticky valid/ack key-event handshake.
// Optional auto-repeat while held is enabled by defining KEY_SCAN_REPEAT_EN.
module key_scan
   import key_scan_pkg::*;
#(
   parameter int SCAN_DIV        = 4096,
   parameter int DEBOUNCE_FRAMES = 3,
   parameter int REPEAT_DELAY    = 40,
   parameter int REPEAT_RATE     = 10
) (
   input  logic                   scanclk,
   input  logic                   reset,
   input  logic [KS_NUM_ROWS-1:0] row_in,
   output logic [KS_NUM_COLS-1:0] col_out,
   output logic                   key_valid,
   output logic [KS_CODE_W-1:0]   key_code,
   output logic                   key_held,
   output logic                   key_overrun,
   input  logic                   key_ack
);
   localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   if (SCAN_DIV < 2 || DEBOUNCE_FRAMES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
      $error("key_scan: parameter out of range");
   end

   logic                 frame_done;
   logic [1:0]           frame_class;
   logic [KS_CODE_W-1:0] frame_code;
   ks_state_t            state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n, cnt_inc;
   logic [KS_CODE_W-1:0] cand, cand_n;
   logic                 cnt_done, press_evt, rpt_evt, key_evt, held_n;

   key_matrix_sampler #(.SCAN_DIV(SCAN_DIV)) u_sampler (
      .scanclk     (scanclk),
      .reset       (reset),
      .row_in      (row_in),
      .col_out     (col_out),
      .frame_done  (frame_done),
      .frame_class (frame_class),
      .frame_code  (frame_code)
   );

   assign cnt_inc  = (int'(cnt) >= DEBOUNCE_FRAMES) ? cnt : cnt + 1'b1;
   assign cnt_done = (int'(cnt) + 1) >= DEBOUNCE_FRAMES;

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      cand_n    = cand;
      press_evt = 1'b0;
      if (frame_done) begin
         case (state)
            ST_IDLE: begin
               if (frame_class == FC_SINGLE) begin
                  cand_n = frame_code;
                  if (DEBOUNCE_FRAMES <= 1) begin
                     state_n   = ST_PRESSED;
                     cnt_n     = '0;
                     press_evt = 1'b1;
                  end else begin
                     state_n = ST_DEBOUNCE;
                     cnt_n   = CNT_ONE;
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (frame_class == FC_SINGLE && frame_code == cand) begin
                  cnt_n = cnt_inc;
                  if (cnt_done) begin
                     state_n   = ST_PRESSED;
                     cnt_n     = '0;
                     press_evt = 1'b1;
                  end
               end else begin
                  state_n = ST_IDLE;
                  cnt_n   = '0;
               end
            end
            ST_PRESSED: begin
               if (frame_class == FC_NONE) begin
                  state_n = (DEBOUNCE_FRAMES <= 1) ? ST_IDLE : ST_RELEASE;
                  cnt_n   = (DEBOUNCE_FRAMES <= 1) ? '0 : CNT_ONE;
               end
            end
            default: begin
               if (frame_class == FC_NONE) begin
                  cnt_n = cnt_inc;
                  if (cnt_done) begin
                     state_n = ST_IDLE;
                     cnt_n   = '0;
                  end
               end else begin
                  // Bounce back to held without a new event.
                  state_n = ST_PRESSED;
                  cnt_n   = '0;
               end
            end
         endcase
      end
   end

   assign held_n  = (state_n == ST_PRESSED) || (state_n == ST_RELEASE);
   assign key_evt = press_evt || rpt_evt;

`ifdef KEY_SCAN_REPEAT_EN
   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

   logic [HOLD_W-1:0] hold, hold_n;
   logic              rep_phase, rep_phase_n;

   // rep_phase selects the initial delay (0) or the steady repeat period (1).
   always_comb begin
      hold_n      = hold;
      rep_phase_n = rep_phase;
      rpt_evt     = 1'b0;
      if (frame_done) begin
         if (state_n == ST_IDLE || press_evt) begin
            hold_n      = '0;
            rep_phase_n = 1'b0;
         end else if (state == ST_PRESSED || state == ST_RELEASE) begin
            if ((int'(hold) + 1) >= (rep_phase ? REPEAT_RATE : REPEAT_DELAY)) begin
               rpt_evt     = 1'b1;
               hold_n      = '0;
               rep_phase_n = 1'b1;
            end else begin
               hold_n = hold + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge scanclk or posedge reset) begin
      if (reset) begin
         hold      <= '0;
         rep_phase <= 1'b0;
      end else begin
         hold      <= hold_n;
         rep_phase <= rep_phase_n;
      end
   end
`else
   assign rpt_evt = 1'b0;
`endif

   always_ff @(posedge scanclk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         cand     <= '0;
         key_held <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         cand     <= cand_n;
         key_held <= held_n;
      end
   end

   // An event in the same cycle as an ack wins, and the ack cancels the overrun.
   always_ff @(posedge scanclk or posedge reset) begin
      if (reset) begin
         key_valid   <= 1'b0;
         key_code    <= '0;
         key_overrun <= 1'b0;
      end else if (key_evt) begin
         key_valid   <= 1'b1;
         key_code    <= cand_n;
         key_overrun <= !key_ack && (key_valid || key_overrun);
      end else if (key_ack) begin
         key_valid   <= 1'b0;
         key_overrun <= 1'b0;
      end
   end
endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: keypad model, table of frame-aligned vectors, event scoreboard.
module tb_key_scan;
   localparam int SCAN_DIV = 4;
   localparam int DF       = 3;
   localparam int RD       = 4;
   localparam int RR       = 2;
   localparam int FRAME    = 4 * SCAN_DIV;

   logic       scanclk = 1'b0;
   logic       reset   = 1'b1;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_held;
   logic       key_overrun;
   logic       key_ack = 1'b0;
   logic [15:0] keys   = '0;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic [3:0] exp_q[$];
   int         ev_frames[$];
   logic       pv = 1'b0;
   logic       po = 1'b0;

   typedef struct {
      logic [15:0] keys;
      int          frames;
      bit          ack;
      bit          push;
      logic [3:0]  push_code;
      logic        valid;
      logic [3:0]  code;
      logic        held;
      logic        ovr;
   } vec_t;
   vec_t tbl[13];

   always #5 scanclk = ~scanclk;

   key_scan #(
      .SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DF), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
   ) dut (
      .scanclk     (scanclk),
      .reset       (reset),
      .row_in      (row_in),
      .col_out     (col_out),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .key_held    (key_held),
      .key_overrun (key_overrun),
      .key_ack     (key_ack)
   );

   // Keypad: a closed key pulls its row low while its column is driven low.
   always_comb begin
      row_in = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (keys[c*4+r] && !col_out[c])
               row_in[r] = 1'b0;
   end

   always @(posedge scanclk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // New events show up as a rising key_valid, or a rising key_overrun when valid was pending.
   always @(negedge scanclk) begin
      if (reset) begin
         pv <= 1'b0;
         po <= 1'b0;
      end else begin
         if ((key_valid && !pv) || (key_overrun && !po)) begin
            ev_frames.push_back(cyc / FRAME);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: got code %0h expected no event (cycle %0d)", key_code, cyc);
            end else begin
               check("event_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
            end
         end
         pv <= key_valid;
         po <= key_overrun;
      end
   end

   initial begin
      int n_exp;
      //          keys      fr ack push pcode  vld code held ovr
      tbl[0]  = '{16'h0000, 1, 0, 0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
      tbl[1]  = '{16'h0200, 2, 0, 0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
      tbl[2]  = '{16'h0200, 1, 0, 1, 4'h9, 1'b1, 4'h9, 1'b1, 1'b0};
      tbl[3]  = '{16'h0200, 2, 0, 0, 4'h0, 1'b1, 4'h9, 1'b1, 1'b0};
      tbl[4]  = '{16'h0000, 2, 0, 0, 4'h0, 1'b1, 4'h9, 1'b1, 1'b0};
      tbl[5]  = '{16'h0000, 1, 0, 0, 4'h0, 1'b1, 4'h9, 1'b0, 1'b0};
      tbl[6]  = '{16'h0004, 3, 0, 1, 4'h2, 1'b1, 4'h2, 1'b1, 1'b1};
      tbl[7]  = '{16'h0000, 3, 1, 0, 4'h0, 1'b0, 4'h2, 1'b0, 1'b0};
      tbl[8]  = '{16'h0080, 2, 1, 0, 4'h0, 1'b0, 4'h2, 1'b0, 1'b0};
      tbl[9]  = '{16'h0000, 1, 0, 0, 4'h0, 1'b0, 4'h2, 1'b0, 1'b0};
      tbl[10] = '{16'h0011, 6, 0, 0, 4'h0, 1'b0, 4'h2, 1'b0, 1'b0};
      tbl[11] = '{16'h0000, 1, 0, 0, 4'h0, 1'b0, 4'h2, 1'b0, 1'b0};
      tbl[12] = '{16'h0020, 3, 0, 1, 4'h5, 1'b1, 4'h5, 1'b1, 1'b0};

      // Reset values and column sequence
      repeat (3) @(negedge scanclk);
      check("rst_col_out", {28'd0, col_out}, 32'hE);
      check("rst_valid", {31'd0, key_valid}, 32'd0);
      check("rst_code", {28'd0, key_code}, 32'd0);
      check("rst_held", {31'd0, key_held}, 32'd0);
      check("rst_overrun", {31'd0, key_overrun}, 32'd0);
      reset = 1'b0;
      repeat (4) @(negedge scanclk);
      check("col_after_4", {28'd0, col_out}, 32'hD);
      repeat (4) @(negedge scanclk);
      check("col_after_8", {28'd0, col_out}, 32'hB);
      repeat (8) @(negedge scanclk);
      check("col_after_16", {28'd0, col_out}, 32'hE);

      // Frame-aligned vectors; an ack is pulsed in the first cycle of its vector
      foreach (tbl[i]) begin
         keys    = tbl[i].keys;
         key_ack = tbl[i].ack;
         if (tbl[i].push) exp_q.push_back(tbl[i].push_code);
         @(negedge scanclk);
         key_ack = 1'b0;
         if (tbl[i].ack) begin
            check($sformatf("v%0d_ack_valid", i), {31'd0, key_valid}, 32'd0);
            check($sformatf("v%0d_ack_overrun", i), {31'd0, key_overrun}, 32'd0);
         end
         repeat (tbl[i].frames * FRAME - 1) @(negedge scanclk);
         check($sformatf("v%0d_valid", i), {31'd0, key_valid}, {31'd0, tbl[i].valid});
         check($sformatf("v%0d_code", i), {28'd0, key_code}, {28'd0, tbl[i].code});
         check($sformatf("v%0d_held", i), {31'd0, key_held}, {31'd0, tbl[i].held});
         check($sformatf("v%0d_overrun", i), {31'd0, key_overrun}, {31'd0, tbl[i].ovr});
      end

      // Mid-frame reset drops the pending event and held key
      repeat (5) @(negedge scanclk);
      reset = 1'b1;
      #1;
      check("midrst_valid", {31'd0, key_valid}, 32'd0);
      check("midrst_held", {31'd0, key_held}, 32'd0);
      check("midrst_code", {28'd0, key_code}, 32'd0);
      check("midrst_col", {28'd0, col_out}, 32'hE);

      // Hold key 5 for 10 frames, acking each event
      keys = 16'h0020;
      repeat (2) @(negedge scanclk);
      ev_frames.delete();
`ifdef KEY_SCAN_REPEAT_EN
      n_exp = 3;
`else
      n_exp = 1;
`endif
      for (int k = 0; k < n_exp; k++) exp_q.push_back(4'h5);
      reset = 1'b0;
      for (int t = 0; t < 10 * FRAME; t++) begin
         @(negedge scanclk);
         key_ack = key_valid;
      end
      key_ack = 1'b0;
      check("repeat_count", ev_frames.size(), n_exp);
      if (ev_frames.size() >= 1) check("repeat_f0", ev_frames[0], 3);
`ifdef KEY_SCAN_REPEAT_EN
      if (ev_frames.size() >= 2) check("repeat_f1", ev_frames[1], 7);
      if (ev_frames.size() >= 3) check("repeat_f2", ev_frames[2], 9);
`endif
      check("held_during_repeat", {31'd0, key_held}, 32'd1);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/key_scan.md
# key_scan

Matrix keypad scanner for the 4×4 player-input keypad, the input-side counterpart of the multiplexed seven-segment display driver. It drives one keypad column low at a time, samples the four row lines, resolves single-key presses, debounces over whole scan frames, and presents a 4-bit key code with a sticky valid/ack handshake to the bus-side logic. It sits in the timer/display IP next to the display driver and shares its slow scan clock.

## Interface
- `SCAN_DIV`, 4096: `scanclk` cycles per column; must be ≥2.
- `DEBOUNCE_FRAMES`, 3: consecutive identical frames required to accept a press, and empty frames required to accept a release; must be ≥1.
- `REPEAT_DELAY`, 40: frames from acceptance to the first auto-repeat. Used only with `KEY_SCAN_REPEAT_EN`.
- `REPEAT_RATE`, 10: frames between later auto-repeats. Used only with `KEY_SCAN_REPEAT_EN`.
- `scanclk` in 1: scan clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `row_in` in 4: keypad rows, pulled up externally; 0 = key closed on the driven column.
- `col_out` out 4: one-cold column drive.
- `key_valid` out 1: key event pending; sticky until acked.
- `key_code` out 4: code of the last accepted key, `{col_idx[1:0], row_idx[1:0]}`.
- `key_held` out 1: debounced key is currently down.
- `key_overrun` out 1: sticky; a new event arrived while `key_valid` was still 1.
- `key_ack` in 1: consumer acknowledge, sampled at the rising edge.

## Operation
- Column sequence: 1110 → 1101 → 1011 → 0111 → 1110. The drive advances when the divider reaches `SCAN_DIV-1`.
- Rows are sampled on the last cycle of each column period, which gives `SCAN_DIV-1` cycles of settling time. Four column periods make one frame.
- At frame end, the 16 samples are classified:
  - NONE: no closures.
  - SINGLE(code): exactly one closure.
  - MULTI: two or more closures. MULTI is treated as ghosting and is never decoded.
- FSM states are IDLE, DEBOUNCE, PRESSED and RELEASE.
  - IDLE: SINGLE(c) moves to DEBOUNCE with candidate=c and count=1. If `DEBOUNCE_FRAMES`=1, it goes straight to PRESSED with an event.
  - DEBOUNCE: SINGLE with the same candidate increments count. When count reaches `DEBOUNCE_FRAMES`, the block moves to PRESSED and raises an event. Any other class returns to IDLE.
  - PRESSED: `key_held`=1. NONE moves to RELEASE with count=1. SINGLE or MULTI stays in PRESSED; a different key is not reported until release.
  - RELEASE: NONE increments count; at `DEBOUNCE_FRAMES` the block moves to IDLE and drops `key_held`. SINGLE or MULTI returns to PRESSED and does not raise an event.
- On an event:
  - `key_code` is set to the candidate and `key_valid` is set to 1.
  - If `key_valid` was already 1 in that cycle, `key_overrun` is set to 1.
- `key_ack` clears `key_valid` and `key_overrun`. If an ack and an event land in the same cycle, the event wins: valid=1, new code, overrun=0.
- `key_ack` while `key_valid`=0 has no effect.

## Timing
- Reset values: `col_out`=4'b1110, `key_valid`=0, `key_code`=0, `key_held`=0, `key_overrun`=0, FSM=IDLE, all counters 0.
- Reset mid-frame aborts the frame. Any pending event is lost.
- Frame length is 4·`SCAN_DIV` cycles.
- Classification and FSM update happen at the edge that ends column 3. All outputs are registered and change on that edge.
- Press latency: `key_valid` rises at the end of the `DEBOUNCE_FRAMES`-th consecutive frame that contains the key.
- Release latency: `key_held` falls at the end of the `DEBOUNCE_FRAMES`-th consecutive empty frame.
- `key_ack` takes effect at the next edge. `key_valid` is low in the following cycle unless a new event occurred at that edge.
- Counters saturate and never wrap. The column index wraps 3→0.

## Configuration
- `KEY_SCAN_REPEAT_EN` defined:
  - In PRESSED and RELEASE, a hold counter counts frames.
  - After `REPEAT_DELAY` frames a repeat event is raised, then one every `REPEAT_RATE` frames.
  - Repeat events use the same `key_code` and follow the same overrun rules.
  - The hold counter resets on entry to PRESSED from DEBOUNCE.
- `KEY_SCAN_REPEAT_EN` undefined: there is exactly one event per press. The repeat counter and the `REPEAT_*` parameters are unused and have no logic.

## Structure
- `key_scan_pkg` holds:
  - The state enum.
  - `KS_NUM_COLS`=4 and `KS_NUM_ROWS`=4.
  - `KS_CODE_W`=4.
  - The frame-class encoding (NONE/SINGLE/MULTI).
- Sub-module `key_matrix_sampler`: column divider, `col_out` drive, row sampling, and frame classification. It outputs a one-cycle `frame_done` strobe together with class and code.
- Top level: FSM, debounce/repeat counters, handshake registers.

## Test plan
- SCAN_DIV=4, DEBOUNCE_FRAMES=3, all rows high, reset released → `col_out` 1110; 1101 after 4 cycles; 1110 again after 16 cycles; all other outputs 0.
- Hold col2/row1 (row_in[1]=0 while col_out[2]=0) for 5 frames → `key_valid`=1 at end of frame 3, `key_code`=4'h9, `key_held`=1. After release, `key_held`=0 after 3 empty frames.
- Press col1/row3 for 2 frames, then release → no `key_valid`, FSM back in IDLE.
- Hold col0/row0 and col1/row0 together for 6 frames → no event, `key_held`=0.
- Accept 4'h9, do not ack, release, then accept 4'h2 → `key_code`=4'h2, `key_overrun`=1. Pulse `key_ack` → both flags 0 next cycle.
- With `KEY_SCAN_REPEAT_EN`, REPEAT_DELAY=4, REPEAT_RATE=2, hold 4'h5 for 10 frames, acking each event → events at the ends of frames 3, 7 and 9. Without the macro → a single event at frame 3.
